// File: rtl/reg_file.sv
// reg_file -- architectural integer register file with a pending-load scoreboard.
//
// Captures the writeback result into one of NREG registers and serves two
// combinational read ports to decode. x0 reads as zero and ignores writes.
// A per-register busy bit marks registers whose load result has not arrived
// yet; the read-side busy flags and stall feed the issue/stall logic.
//
// Parameters:
//   XLEN   register and data width
//   NREG   number of architectural registers (address width = $clog2(NREG))
//   BYPASS 1: writeback data and busy-clear are visible on the read ports in
//             the same cycle as wb_en; 0: visible from the next cycle
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   wb_en/wb_rd/wb_data  writeback valid, destination, value
//   rs1_addr/rs2_addr  read addresses
//   rs1_data/rs2_data  read data, combinational
//   busy_set/busy_rd   mark busy_rd as pending (load issued)
//   rs1_busy/rs2_busy  read address has a pending write, combinational
//   stall              rs1_busy | rs2_busy
//   busy_count         number of pending registers, registered
module reg_file #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wb_en,
  input  logic [$clog2(NREG)-1:0]     wb_rd,
  input  logic [XLEN-1:0]             wb_data,
  input  logic [$clog2(NREG)-1:0]     rs1_addr,
  input  logic [$clog2(NREG)-1:0]     rs2_addr,
  output logic [XLEN-1:0]             rs1_data,
  output logic [XLEN-1:0]             rs2_data,
  input  logic                        busy_set,
  input  logic [$clog2(NREG)-1:0]     busy_rd,
  output logic                        rs1_busy,
  output logic                        rs2_busy,
  output logic                        stall,
  output logic [$clog2(NREG+1)-1:0]   busy_count
);

  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  logic wb_live;
  logic hit1, hit2;
  logic set1, set2;

  // Number of set bits in the scoreboard vector.
  function automatic logic [CW-1:0] popcount(input logic [NREG-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // A writeback to x0 is a no-op for both data and scoreboard.
  assign wb_live = wb_en && (wb_rd != '0);

  // Register storage. Entry 0 is held at zero and never written, so it
  // collapses to a constant; reads of x0 are also forced to zero below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (wb_live && (wb_rd == AW'(i))) begin
          regs[i] <= wb_data;
        end
      end
    end
  end

  // Scoreboard next state: clear on writeback first, then set, so a new load
  // issued in the same cycle as the old result's writeback keeps the
  // register busy for the newer load.
  always_comb begin
    busy_nxt = busy;
    if (wb_live) begin
      busy_nxt[wb_rd] = 1'b0;
    end
    if (busy_set && (busy_rd != '0)) begin
      busy_nxt[busy_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // busy_count is the popcount of the next-state vector, registered, so it
  // always matches the busy bits it sits beside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= popcount(busy_nxt);
    end
  end

  // Read side. A bypass hit means the register is being written this cycle;
  // the busy flag is suppressed by that writeback unless a new load targets
  // the same register in the same cycle.
  always_comb begin
    hit1 = (BYPASS != 0) && wb_en && (wb_rd == rs1_addr);
    hit2 = (BYPASS != 0) && wb_en && (wb_rd == rs2_addr);
    set1 = busy_set && (busy_rd == rs1_addr);
    set2 = busy_set && (busy_rd == rs2_addr);

    rs1_data = '0;
    rs2_data = '0;
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;

    if (rs1_addr != '0) begin
      rs1_data = hit1 ? wb_data : regs[rs1_addr];
      rs1_busy = busy[rs1_addr] && !(hit1 && !set1);
    end
    if (rs2_addr != '0) begin
      rs2_data = hit2 ? wb_data : regs[rs2_addr];
      rs2_busy = busy[rs2_addr] && !(hit2 && !set2);
    end

    stall = rs1_busy | rs2_busy;
  end

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        busy_set;
  logic [4:0]  busy_rd;

  logic [63:0] rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy, stall;
  logic [5:0]  busy_count;

  logic [63:0] nb_rs1_data, nb_rs2_data;
  logic        nb_rs1_busy, nb_rs2_busy, nb_stall;
  logic [5:0]  nb_busy_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  reg_file #(.XLEN(64), .NREG(32), .BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .busy_set(busy_set), .busy_rd(busy_rd),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .stall(stall), .busy_count(busy_count)
  );

  reg_file #(.XLEN(64), .NREG(32), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data),
    .busy_set(busy_set), .busy_rd(busy_rd),
    .rs1_busy(nb_rs1_busy), .rs2_busy(nb_rs2_busy),
    .stall(nb_stall), .busy_count(nb_busy_count)
  );

  typedef struct {
    logic        wen;
    logic [4:0]  wrd;
    logic [63:0] wdat;
    logic        bset;
    logic [4:0]  brd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [63:0] e_d1;
    logic [63:0] e_d2;
    logic        e_b1;
    logic        e_b2;
    logic [5:0]  e_cnt;
    logic [63:0] e_nd1;
    logic        e_nb1;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic wen, input logic [4:0] wrd, input logic [63:0] wdat,
    input logic bset, input logic [4:0] brd,
    input logic [4:0] a1, input logic [4:0] a2,
    input logic [63:0] e_d1, input logic [63:0] e_d2,
    input logic e_b1, input logic e_b2, input logic [5:0] e_cnt,
    input logic [63:0] e_nd1, input logic e_nb1);
    vec_t v;
    v.wen = wen; v.wrd = wrd; v.wdat = wdat; v.bset = bset; v.brd = brd;
    v.a1 = a1; v.a2 = a2; v.e_d1 = e_d1; v.e_d2 = e_d2;
    v.e_b1 = e_b1; v.e_b2 = e_b2; v.e_cnt = e_cnt;
    v.e_nd1 = e_nd1; v.e_nb1 = e_nb1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic wen, input logic [4:0] wrd, input logic [63:0] wdat,
                       input logic bset, input logic [4:0] brd,
                       input logic [4:0] a1, input logic [4:0] a2);
    wb_en = wen; wb_rd = wrd; wb_data = wdat;
    busy_set = bset; busy_rd = brd;
    rs1_addr = a1; rs2_addr = a2;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    // Each row is one cycle: inputs applied after the falling edge, outputs
    // checked before the next rising edge, which then commits the row.
    //             wen  wrd     wdat                       bset brd    a1     a2     e_d1                       e_d2      b1 b2 cnt    nb_d1                      nb_b1
    vecs[0]  = mk(0, 5'd0,  64'd0,                     0, 5'd0,  5'd1,  5'd31, 64'd0,                     64'd0,    0, 0, 6'd0, 64'd0,                     0);
    vecs[1]  = mk(1, 5'd5,  64'hDEADBEEF_CAFEF00D,     0, 5'd0,  5'd5,  5'd0,  64'hDEADBEEF_CAFEF00D,     64'd0,    0, 0, 6'd0, 64'd0,                     0);
    vecs[2]  = mk(1, 5'd0,  64'h1234,                  0, 5'd0,  5'd5,  5'd0,  64'hDEADBEEF_CAFEF00D,     64'd0,    0, 0, 6'd0, 64'hDEADBEEF_CAFEF00D,     0);
    vecs[3]  = mk(0, 5'd0,  64'd0,                     0, 5'd0,  5'd5,  5'd0,  64'hDEADBEEF_CAFEF00D,     64'd0,    0, 0, 6'd0, 64'hDEADBEEF_CAFEF00D,     0);
    vecs[4]  = mk(1, 5'd7,  64'hA5,                    0, 5'd0,  5'd7,  5'd7,  64'hA5,                    64'hA5,   0, 0, 6'd0, 64'd0,                     0);
    vecs[5]  = mk(0, 5'd0,  64'd0,                     0, 5'd0,  5'd7,  5'd7,  64'hA5,                    64'hA5,   0, 0, 6'd0, 64'hA5,                    0);
    vecs[6]  = mk(0, 5'd0,  64'd0,                     1, 5'd3,  5'd3,  5'd3,  64'd0,                     64'd0,    0, 0, 6'd0, 64'd0,                     0);
    vecs[7]  = mk(0, 5'd0,  64'd0,                     0, 5'd0,  5'd3,  5'd0,  64'd0,                     64'd0,    1, 0, 6'd1, 64'd0,                     1);
    vecs[8]  = mk(1, 5'd3,  64'h42,                    0, 5'd0,  5'd3,  5'd3,  64'h42,                    64'h42,   0, 0, 6'd1, 64'd0,                     1);
    vecs[9]  = mk(0, 5'd0,  64'd0,                     0, 5'd0,  5'd3,  5'd3,  64'h42,                    64'h42,   0, 0, 6'd0, 64'h42,                    0);
    vecs[10] = mk(0, 5'd0,  64'd0,                     1, 5'd9,  5'd9,  5'd0,  64'd0,                     64'd0,    0, 0, 6'd0, 64'd0,                     0);
    vecs[11] = mk(0, 5'd0,  64'd0,                     0, 5'd0,  5'd9,  5'd0,  64'd0,                     64'd0,    1, 0, 6'd1, 64'd0,                     1);
    vecs[12] = mk(1, 5'd9,  64'h99,                    1, 5'd9,  5'd9,  5'd0,  64'h99,                    64'd0,    1, 0, 6'd1, 64'd0,                     1);
    vecs[13] = mk(1, 5'd9,  64'h77,                    1, 5'd10, 5'd9,  5'd10, 64'h77,                    64'd0,    0, 0, 6'd1, 64'h99,                    1);
    vecs[14] = mk(0, 5'd0,  64'd0,                     0, 5'd0,  5'd9,  5'd10, 64'h77,                    64'd0,    0, 1, 6'd1, 64'h77,                    0);
    vecs[15] = mk(0, 5'd0,  64'd0,                     1, 5'd10, 5'd10, 5'd0,  64'd0,                     64'd0,    1, 0, 6'd1, 64'd0,                     1);
    vecs[16] = mk(1, 5'd12, 64'h5,                     0, 5'd0,  5'd10, 5'd12, 64'd0,                     64'h5,    1, 0, 6'd1, 64'd0,                     1);
    vecs[17] = mk(0, 5'd0,  64'd0,                     1, 5'd0,  5'd0,  5'd12, 64'd0,                     64'h5,    0, 0, 6'd1, 64'd0,                     0);
    vecs[18] = mk(0, 5'd0,  64'd0,                     0, 5'd0,  5'd0,  5'd10, 64'd0,                     64'd0,    0, 1, 6'd1, 64'd0,                     0);

    // Reset state
    rst = 1'b1;
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd1, 5'd31);
    repeat (2) @(negedge clk);
    #2;
    chk("rst_rs1_data", rs1_data, 64'd0);
    chk("rst_rs2_data", rs2_data, 64'd0);
    chk("rst_busy_count", 64'(busy_count), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].wen, vecs[i].wrd, vecs[i].wdat, vecs[i].bset, vecs[i].brd,
            vecs[i].a1, vecs[i].a2);
      #2;
      chk($sformatf("v%0d_rs1_data", i), rs1_data, vecs[i].e_d1);
      chk($sformatf("v%0d_rs2_data", i), rs2_data, vecs[i].e_d2);
      chk($sformatf("v%0d_rs1_busy", i), 64'(rs1_busy), 64'(vecs[i].e_b1));
      chk($sformatf("v%0d_rs2_busy", i), 64'(rs2_busy), 64'(vecs[i].e_b2));
      chk($sformatf("v%0d_stall", i), 64'(stall), 64'(vecs[i].e_b1 | vecs[i].e_b2));
      chk($sformatf("v%0d_busy_count", i), 64'(busy_count), 64'(vecs[i].e_cnt));
      chk($sformatf("v%0d_nb_rs1_data", i), nb_rs1_data, vecs[i].e_nd1);
      chk($sformatf("v%0d_nb_rs1_busy", i), 64'(nb_rs1_busy), 64'(vecs[i].e_nb1));
    end

    // Fill the scoreboard: only x10 is busy now, so after marking x1..x31 the
    // count saturates at 31 with no wrap.
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 64'd0, 1'b1, 5'(r), 5'd0, 5'd0);
    end
    @(negedge clk);
    idle();
    #2;
    chk("full_busy_count", 64'(busy_count), 64'd31);
    @(negedge clk);
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 5'd31, 5'd1);
    #2;
    chk("full_reset_busy_count", 64'(busy_count), 64'd31);
    chk("full_stall", 64'(stall), 64'd1);

    // Write x2 (clears its busy bit), then reset between edges.
    @(negedge clk);
    drive(1'b1, 5'd2, 64'hFF, 1'b0, 5'd0, 5'd2, 5'd0);
    @(negedge clk);
    idle();
    rs1_addr = 5'd2;
    rs2_addr = 5'd4;
    #2;
    chk("pre_rst_x2", rs1_data, 64'hFF);
    chk("pre_rst_busy_count", 64'(busy_count), 64'd30);
    chk("pre_rst_x4_busy", 64'(rs2_busy), 64'd1);
    // Mid-cycle reset, with a busy_set and a writeback held on the inputs.
    drive(1'b1, 5'd6, 64'h66, 1'b1, 5'd5, 5'd2, 5'd6);
    rst = 1'b1;
    #1;
    chk("midrst_x2", rs1_data, 64'd0);
    chk("midrst_bypass_x6", rs2_data, 64'h66);
    chk("midrst_nb_x6", nb_rs2_data, 64'd0);
    chk("midrst_busy_count", 64'(busy_count), 64'd0);
    chk("midrst_stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    rs1_addr = 5'd5;
    rs2_addr = 5'd6;
    #2;
    chk("postrst_x5_busy", 64'(rs1_busy), 64'd0);
    chk("postrst_x6_data", rs2_data, 64'd0);
    chk("postrst_busy_count", 64'(busy_count), 64'd0);
    @(negedge clk);
    #2;
    chk("postrst2_busy_count", 64'(busy_count), 64'd0);
    chk("postrst2_stall", 64'(stall), 64'd0);

    // First write after reset is accepted.
    @(negedge clk);
    drive(1'b1, 5'd6, 64'h123, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    idle();
    rs1_addr = 5'd6;
    #2;
    chk("first_write_x6", rs1_data, 64'h123);
    chk("first_write_nb_x6", nb_rs1_data, 64'h123);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
